// File: rtl/puzzle_move_ctrl.sv
// rtl/puzzle_move_ctrl.sv - sliding 2x3 puzzle move sequencer over a shared register file
module puzzle_move_ctrl #(
    parameter int          BOARD_REG = 0,
    parameter int          CNT_REG   = 1,
    parameter int          ORD_REG   = 2,
    parameter logic [17:0] GOAL      = 18'h058D1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mv_valid,
    input  logic [1:0]  mv_dir,
    output logic        mv_ready,
    output logic [3:0]  rf_src0,
    output logic [3:0]  rf_src1,
    input  logic [39:0] rf_data0,
    input  logic [39:0] rf_data1,
    output logic [3:0]  rf_dst,
    output logic        rf_we,
    output logic [39:0] rf_wdata,
    output logic        done_valid,
    output logic        done_legal,
    output logic        solved
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD1 = 3'd1;
    localparam logic [2:0] S_LOAD2 = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_WC    = 3'd5;
    localparam logic [2:0] S_WO    = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;

    localparam logic [3:0] BOARD_A = 4'(BOARD_REG);
    localparam logic [3:0] CNT_A   = 4'(CNT_REG);
    localparam logic [3:0] ORD_A   = 4'(ORD_REG);

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [17:0] board_q, board_d;
    logic [39:0] cnt_q, cnt_d;
    logic [39:0] ord_q, ord_d;
    logic        legal_q, legal_d;
    logic        solved_q, solved_d;

    logic [2:0]  blank_cnt;
    int          b_idx;
    int          t_idx;
    logic        dir_ok;
    logic        calc_legal;
    logic [17:0] res_board;

    // Locate the blank and derive the swap target from the captured board.
    always_comb begin
        blank_cnt = 3'd0;
        b_idx     = 0;
        for (int k = 0; k < 6; k++) begin
            if (board_q[3*k +: 3] == 3'd0) begin
                blank_cnt = blank_cnt + 3'd1;
                b_idx     = k;
            end
        end
        case (dir_q)
            DIR_UP:   begin dir_ok = (b_idx >= 3);                t_idx = b_idx - 3; end
            DIR_DOWN: begin dir_ok = (b_idx < 3);                 t_idx = b_idx + 3; end
            DIR_LEFT: begin dir_ok = (b_idx != 0) && (b_idx != 3); t_idx = b_idx - 1; end
            default:  begin dir_ok = (b_idx != 2) && (b_idx != 5); t_idx = b_idx + 1; end
        endcase
        calc_legal = (blank_cnt == 3'd1) && dir_ok;
        res_board  = board_q;
        if (calc_legal) begin
            res_board[3*b_idx +: 3] = board_q[3*t_idx +: 3];
            res_board[3*t_idx +: 3] = 3'd0;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        board_d  = board_q;
        cnt_d    = cnt_q;
        ord_d    = ord_q;
        legal_d  = legal_q;
        solved_d = solved_q;
        case (state_q)
            S_IDLE: begin
                if (mv_valid) begin
                    dir_d   = mv_dir;
                    state_d = S_LOAD1;
                end
            end
            S_LOAD1: begin
                board_d = rf_data0[17:0];
                cnt_d   = rf_data1;
                state_d = S_LOAD2;
            end
            S_LOAD2: begin
                ord_d   = rf_data0;
                state_d = S_CALC;
            end
            S_CALC: begin
                board_d = res_board;
                legal_d = calc_legal;
                if (calc_legal) begin
                    state_d = S_WB;
                end else begin
                    solved_d = (res_board == GOAL);
                    state_d  = S_RESP;
                end
            end
            S_WB: state_d = S_WC;
            S_WC: state_d = S_WO;
            S_WO: begin
                solved_d = (board_q == GOAL);
                state_d  = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 2'd0;
            board_q  <= 18'd0;
            cnt_q    <= 40'd0;
            ord_q    <= 40'd0;
            legal_q  <= 1'b0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            board_q  <= board_d;
            cnt_q    <= cnt_d;
            ord_q    <= ord_d;
            legal_q  <= legal_d;
            solved_q <= solved_d;
        end
    end

    always_comb begin
        mv_ready   = 1'b0;
        rf_src0    = 4'd0;
        rf_src1    = 4'd0;
        rf_dst     = 4'd0;
        rf_we      = 1'b0;
        rf_wdata   = 40'd0;
        done_valid = 1'b0;
        done_legal = 1'b0;
        case (state_q)
            S_IDLE:  mv_ready = 1'b1;
            S_LOAD1: begin rf_src0 = BOARD_A; rf_src1 = CNT_A; end
            S_LOAD2: rf_src0 = ORD_A;
            S_WB: begin rf_we = 1'b1; rf_dst = BOARD_A; rf_wdata = {22'd0, board_q}; end
            S_WC: begin rf_we = 1'b1; rf_dst = CNT_A;   rf_wdata = cnt_q + 40'd1; end
            S_WO: begin rf_we = 1'b1; rf_dst = ORD_A;   rf_wdata = {ord_q[37:0], dir_q}; end
            S_RESP: begin done_valid = 1'b1; done_legal = legal_q; end
            default: ;
        endcase
    end

    assign solved = solved_q;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// tb/tb_puzzle_move_ctrl.sv - directed-vector bench for puzzle_move_ctrl
module tb_puzzle_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mv_valid = 1'b0;
    logic [1:0]  mv_dir = 2'd0;
    logic        mv_ready;
    logic [3:0]  rf_src0, rf_src1, rf_dst;
    logic [39:0] rf_data0, rf_data1, rf_wdata;
    logic        rf_we, done_valid, done_legal, solved;

    logic [39:0] rf [16];
    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int mv_no = 0;

    puzzle_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_ready(mv_ready),
        .rf_src0(rf_src0), .rf_src1(rf_src1), .rf_data0(rf_data0), .rf_data1(rf_data1),
        .rf_dst(rf_dst), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .done_valid(done_valid), .done_legal(done_legal), .solved(solved)
    );

    always #5 clk = ~clk;

    assign rf_data0 = rf[rf_src0];
    assign rf_data1 = rf[rf_src1];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_dst] = rf_wdata;
            wr_total   = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s (move %0d): got %h expected %h", tag, mv_no, got, exp);
        end
    endtask

    task automatic load_rf(input logic [39:0] b, input logic [39:0] c, input logic [39:0] o);
        rf[0] = b;
        rf[1] = c;
        rf[2] = o;
    endtask

    task automatic do_move(input logic [1:0] dir, input bit exp_legal, input logic [39:0] eb,
                           input logic [39:0] ec, input logic [39:0] eo, input bit es);
        int lat;
        int first_we;
        int w0;
        int n;
        mv_no = mv_no + 1;
        n = 0;
        while (!mv_ready && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        check("ready_before", 40'(mv_ready), 40'd1);
        w0       = wr_total;
        lat      = 0;
        first_we = 0;
        mv_valid = 1'b1;
        mv_dir   = dir;
        @(posedge clk);
        #1 mv_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rf_we && first_we == 0) first_we = k;
            if (done_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 40'(lat), exp_legal ? 40'd7 : 40'd4);
        check("done_legal", 40'(done_legal), 40'(exp_legal));
        check("solved", 40'(solved), 40'(es));
        check("first_write_cycle", 40'(first_we), exp_legal ? 40'd4 : 40'd0);
        @(negedge clk);
        check("pulse_width", 40'(done_valid), 40'd0);
        check("ready_after", 40'(mv_ready), 40'd1);
        check("solved_hold", 40'(solved), 40'(es));
        check("write_count", 40'(wr_total - w0), exp_legal ? 40'd3 : 40'd0);
        check("board", rf[0], eb);
        check("cnt", rf[1], ec);
        check("ord", rf[2], eo);
    endtask

    initial begin
        int w0;
        bit seen_done;
        logic [39:0] exp_ord;
        logic [39:0] exp_b;
        logic [1:0]  d;

        for (int i = 0; i < 16; i++) rf[i] = 40'd0;
        load_rf(40'h0A958, 40'd0, 40'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done_valid", 40'(done_valid), 40'd0);
        check("rst_done_legal", 40'(done_legal), 40'd0);
        check("rst_solved", 40'(solved), 40'd0);
        check("rst_rf_we", 40'(rf_we), 40'd0);
        check("rst_rf_wdata", rf_wdata, 40'd0);
        check("rst_addrs", {28'd0, rf_src0, rf_src1, rf_dst}, 40'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 40'(mv_ready), 40'd1);

        // right from the reset board
        do_move(2'd3, 1'b1, 40'h0A943, 40'd1, 40'h3, 1'b0);
        // down from the reset board
        load_rf(40'h0A958, 40'd0, 40'd0);
        do_move(2'd1, 1'b1, 40'h0A15C, 40'd1, 40'h1, 1'b0);
        // up and left are off the edge
        load_rf(40'h0A958, 40'd0, 40'd0);
        do_move(2'd0, 1'b0, 40'h0A958, 40'd0, 40'd0, 1'b0);
        do_move(2'd2, 1'b0, 40'h0A958, 40'd0, 40'd0, 1'b0);
        // reach the goal, then an illegal move keeps solved
        load_rf(40'h288D1, 40'd0, 40'd0);
        do_move(2'd3, 1'b1, 40'h058D1, 40'd1, 40'h3, 1'b1);
        do_move(2'd1, 1'b0, 40'h058D1, 40'd1, 40'h3, 1'b1);
        // six blanks, then no blank
        load_rf(40'h00000, 40'd5, 40'd0);
        do_move(2'd3, 1'b0, 40'h00000, 40'd5, 40'd0, 1'b0);
        load_rf(40'h0A953, 40'd5, 40'd0);
        do_move(2'd3, 1'b0, 40'h0A953, 40'd5, 40'd0, 1'b0);
        // counter wrap
        load_rf(40'h0A958, 40'hFF_FFFF_FFFF, 40'd0);
        do_move(2'd3, 1'b1, 40'h0A943, 40'd0, 40'h3, 1'b0);

        // reset during WC
        mv_no = mv_no + 1;
        load_rf(40'h0A958, 40'd0, 40'd0);
        mv_valid = 1'b1;
        mv_dir   = 2'd3;
        @(posedge clk);
        #1 mv_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_in_wc", 40'(rf_dst), 40'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_total;
        check("midrst_we", 40'(rf_we), 40'd0);
        check("midrst_ready", 40'(mv_ready), 40'd1);
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_valid) seen_done = 1'b1;
        end
        check("midrst_no_done", 40'(seen_done), 40'd0);
        check("midrst_no_writes", 40'(wr_total - w0), 40'd0);
        check("midrst_ord", rf[2], 40'd0);
        check("midrst_ready_idle", 40'(mv_ready), 40'd1);

        // 21 alternating right/left moves
        load_rf(40'h0A958, 40'd0, 40'd0);
        exp_ord = 40'd0;
        for (int i = 0; i < 21; i++) begin
            d       = (i % 2 == 0) ? 2'd3 : 2'd2;
            exp_b   = (i % 2 == 0) ? 40'h0A943 : 40'h0A958;
            exp_ord = {exp_ord[37:0], d};
            do_move(d, 1'b1, exp_b, 40'(i + 1), exp_ord, 1'b0);
        end
        check("history_last20", rf[2], 40'hBB_BBBB_BBBB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
